fwd_hazard_unit: RTL

- Parametrised successor to the single-WB-port forwarding logic in the core pipeline.
- Selects an operand source for rs1/rs2 from the register file or any of NUM_BYP bypass stages, using youngest-wins priority.
- Detects two hazards and stalls the ID stage for each:
  - load-use: the matching producer's data is not ready yet;
  - long-latency: the register is busy in a scoreboard. Scoreboard entries are set by multi-cycle (PIM/load-miss) ops issued from ID and cleared on completion.
- Keeps stall statistics and a stall-timeout watchdog.

---
 rtl/fwd_hazard_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: youngest-wins operand forwarding, load-use/scoreboard/WAW stall detection,
// multi-cycle writer scoreboard, saturating stall statistics and a sticky stall-timeout watchdog.
module fwd_hazard_unit #(
   parameter int NUM_BYP   = 2,
   parameter int FSEL_W    = $clog2(NUM_BYP+1),
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_id_valid,
   input  logic [6:0]           i_opcode,
   input  logic [4:0]           i_rs1,
   input  logic [4:0]           i_rs2,
   input  logic [4:0]           i_rd,
   input  logic                 i_id_mc,
   input  logic                 i_flush,
   input  logic [NUM_BYP-1:0]   i_byp_valid,
   input  logic [NUM_BYP-1:0]   i_byp_reg_write,
   input  logic [5*NUM_BYP-1:0] i_byp_rd,
   input  logic [NUM_BYP-1:0]   i_byp_ready,
   input  logic                 i_mc_done,
   input  logic [4:0]           i_mc_rd,
   output logic [FSEL_W-1:0]    o_forward_a,
   output logic [FSEL_W-1:0]    o_forward_b,
   output logic                 o_stall,
   output logic [31:0]          o_sb_busy,
   output logic [CNT_W-1:0]     o_stall_cnt,
   output logic                 o_timeout
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_PIM    = 7'b0001011;
   localparam int RUN_W = $clog2(MAX_STALL+1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL-1);

   logic              use_rs1, use_rs2, rdy_a, rdy_b, hazard, set_en;
   logic [FSEL_W-1:0] fwd_a, fwd_b;
   logic [31:0]       sb, set_v, clr_v;
   logic [CNT_W-1:0]  cnt;
   logic [RUN_W-1:0]  run;
   logic              timeout;

   // Scan oldest to youngest so the youngest match overwrites and wins.
   always_comb begin
      use_rs1 = !(i_opcode inside {OP_JAL, OP_LUI, OP_AUIPC});
      use_rs2 = i_opcode inside {OP_R, OP_STORE, OP_BRANCH, OP_PIM};
      fwd_a = '0;
      fwd_b = '0;
      rdy_a = 1'b1;
      rdy_b = 1'b1;
      for (int k = NUM_BYP-1; k >= 0; k--) begin
         if (use_rs1 && i_rs1 != 5'd0 && i_byp_valid[k] && i_byp_reg_write[k] && i_byp_rd[5*k +: 5] == i_rs1) begin
            fwd_a = FSEL_W'(k+1);
            rdy_a = i_byp_ready[k];
         end
         if (use_rs2 && i_rs2 != 5'd0 && i_byp_valid[k] && i_byp_reg_write[k] && i_byp_rd[5*k +: 5] == i_rs2) begin
            fwd_b = FSEL_W'(k+1);
            rdy_b = i_byp_ready[k];
         end
      end
   end

   always_comb begin
      hazard = !rdy_a || !rdy_b || (use_rs1 && sb[i_rs1]) || (use_rs2 && sb[i_rs2]) ||
               (i_id_mc && i_rd != 5'd0 && sb[i_rd]);
      o_stall = i_id_valid && !i_flush && hazard;
      o_forward_a = i_id_valid ? fwd_a : '0;
      o_forward_b = i_id_valid ? fwd_b : '0;
      set_en = i_id_valid && i_id_mc && !o_stall && !i_flush && i_rd != 5'd0;
      set_v = set_en ? 32'd1 << i_rd : 32'd0;
      clr_v = i_mc_done ? 32'd1 << i_mc_rd : 32'd0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sb      <= '0;
         cnt     <= '0;
         run     <= '0;
         timeout <= 1'b0;
      end else begin
         sb      <= ((sb & ~clr_v) | set_v) & ~32'd1;
         cnt     <= (o_stall && cnt != '1) ? cnt + CNT_W'(1) : cnt;
         run     <= !o_stall ? '0 : (run == RUN_LAST) ? run : run + RUN_W'(1);
         timeout <= timeout || (o_stall && run == RUN_LAST);
      end
   end

   assign o_sb_busy   = sb;
   assign o_stall_cnt = cnt;
   assign o_timeout   = timeout;
endmodule
